// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file writeback arbiter:
//   XLEN       - default register data width
//   REG_IDX_W  - width of a register index
//   NUM_REGS   - number of architectural registers (width of the pending map)
//   arb_state_e- round-robin memory: which source won the last grant
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic [0:0] {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the two writeback request channels (A = ALU, B = load unit), the
// register-file write port and the pending-write map.
//   master : the issuing side - drives requests, observes readies/write port
//   slave  : the arbiter      - accepts requests, drives readies/write port
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int XLEN = regfile_wb_arbiter_pkg::XLEN
);
    import regfile_wb_arbiter_pkg::*;

    logic                 a_valid;
    logic                 a_ready;
    logic [REG_IDX_W-1:0] a_rd;
    logic [XLEN-1:0]      a_data;

    logic                 b_valid;
    logic                 b_ready;
    logic [REG_IDX_W-1:0] b_rd;
    logic [XLEN-1:0]      b_data;

    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_rd;
    logic [XLEN-1:0]      rf_wdata;
    logic [NUM_REGS-1:0]  pending;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  rf_we, rf_rd, rf_wdata, pending
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output rf_we, rf_rd, rf_wdata, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small circular buffer of {rd, data} writeback entries for one source.
// Ports:
//   clk_i, reset_i      - clock, synchronous active-high reset
//   push_i, rd_i, data_i- write an entry (ignored while full)
//   pop_i               - drop the head entry (ignored while empty)
//   full_o, empty_o     - occupancy flags
//   head_rd_o/data_o    - oldest entry
//   ent_valid_o/ent_rd_o- per-slot occupancy and index, for the pending map
// DEPTH must be a power of two (2 or 4).
// ---------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [IDX_W-1:0] rd_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [IDX_W-1:0] head_rd_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic [DEPTH-1:0] ent_valid_o,
    output logic [IDX_W-1:0] ent_rd_o [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] rd_mem_q   [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    // One extra bit so that "full" and "empty" never alias.
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
    endfunction

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == CNT_W'(0));
    assign push_ok     = push_i & ~full_o;
    assign pop_ok      = pop_i & ~empty_o;
    assign head_rd_o   = rd_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign ent_rd_o    = rd_mem_q;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= IDX_W'(0);
                data_mem_q[i] <= WIDTH'(0);
            end
        end else begin
            if (push_ok) begin
                rd_mem_q[wr_ptr_q]   <= rd_i;
                data_mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs        = PTR_W'(0);
        ent_valid_o = DEPTH'(0);
        for (int i = 0; i < DEPTH; i++) begin
            offs           = PTR_W'(i) - rd_ptr_q;
            ent_valid_o[i] = ({1'b0, offs} < count_q);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges two writeback streams (A = ALU, B = load unit) onto one register
// file write port. Each source is buffered in its own wb_fifo; a two-state
// round-robin arbiter picks one head per cycle and loads it into registered
// write-port outputs. Writes to x0 are consumed without raising rf_we.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bus (slave) - a_/b_ request channels, rf_we/rf_rd/rf_wdata, pending map
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN  = regfile_wb_arbiter_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);
    import regfile_wb_arbiter_pkg::*;

    logic                 a_full, a_empty, b_full, b_empty;
    logic                 a_push, b_push;
    logic [REG_IDX_W-1:0] a_head_rd, b_head_rd;
    logic [XLEN-1:0]      a_head_data, b_head_data;
    logic [DEPTH-1:0]     a_ent_valid, b_ent_valid;
    logic [REG_IDX_W-1:0] a_ent_rd [DEPTH];
    logic [REG_IDX_W-1:0] b_ent_rd [DEPTH];

    arb_state_e           state_q, state_d;
    logic                 grant_a, grant_b;

    logic                 rf_we_q, rf_we_d;
    logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0]  pending_s;

    // Readiness is purely "not full": a pop in the same cycle does not free a slot.
    assign bus.a_ready = ~a_full;
    assign bus.b_ready = ~b_full;
    assign a_push      = bus.a_valid & ~a_full;
    assign b_push      = bus.b_valid & ~b_full;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN), .IDX_W(REG_IDX_W)) u_fifo_a (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (a_push),
        .rd_i        (bus.a_rd),
        .data_i      (bus.a_data),
        .pop_i       (grant_a),
        .full_o      (a_full),
        .empty_o     (a_empty),
        .head_rd_o   (a_head_rd),
        .head_data_o (a_head_data),
        .ent_valid_o (a_ent_valid),
        .ent_rd_o    (a_ent_rd)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN), .IDX_W(REG_IDX_W)) u_fifo_b (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (b_push),
        .rd_i        (bus.b_rd),
        .data_i      (bus.b_data),
        .pop_i       (grant_b),
        .full_o      (b_full),
        .empty_o     (b_empty),
        .head_rd_o   (b_head_rd),
        .head_data_o (b_head_data),
        .ent_valid_o (b_ent_valid),
        .ent_rd_o    (b_ent_rd)
    );

    // Arbiter state register; reset to LAST_B so A wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LAST_B;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin grant and next state; a lone requester is granted outright.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        state_d = state_q;
        case ({~a_empty, ~b_empty})
            2'b10: begin
                grant_a = 1'b1;
                state_d = LAST_A;
            end
            2'b01: begin
                grant_b = 1'b1;
                state_d = LAST_B;
            end
            2'b11: begin
                if (state_q == LAST_B) begin
                    grant_a = 1'b1;
                    state_d = LAST_A;
                end else begin
                    grant_b = 1'b1;
                    state_d = LAST_B;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Next write-port values: load the granted head, suppress the enable for x0.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_a) begin
            rf_we_d    = (a_head_rd != REG_IDX_W'(0));
            rf_rd_d    = a_head_rd;
            rf_wdata_d = a_head_data;
        end else if (grant_b) begin
            rf_we_d    = (b_head_rd != REG_IDX_W'(0));
            rf_rd_d    = b_head_rd;
            rf_wdata_d = b_head_data;
        end else begin
            rf_we_d    = 1'b0;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= REG_IDX_W'(0);
            rf_wdata_q <= XLEN'(0);
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Pending map: every buffered entry plus the write currently on the port.
    always_comb begin
        pending_s = NUM_REGS'(0);
        for (int i = 0; i < DEPTH; i++) begin
            pending_s[a_ent_rd[i]] = pending_s[a_ent_rd[i]] | a_ent_valid[i];
            pending_s[b_ent_rd[i]] = pending_s[b_ent_rd[i]] | b_ent_valid[i];
        end
        pending_s[rf_rd_q] = pending_s[rf_rd_q] | rf_we_q;
        // x0 is never architecturally written, so never reported pending.
        pending_s[0] = 1'b0;
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.pending  = pending_s;

endmodule
